// File: rtl/fp8_round_pack_if.sv
// Handshake and data bus of the fp8 round/pack stage: the upstream result
// interface and the downstream FIFO-head interface.
interface fp8_round_pack_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_sign;
  logic [2:0] in_big_exp;
  logic [2:0] in_shift;
  logic [7:0] in_mant;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] out_flags;

  modport master (
    output in_valid, in_sign, in_big_exp, in_shift, in_mant, out_ready,
    input  in_ready, out_valid, out_data, out_flags
  );

  modport slave (
    input  in_valid, in_sign, in_big_exp, in_shift, in_mant, out_ready,
    output in_ready, out_valid, out_data, out_flags
  );
endinterface

// File: rtl/fp8_round_pack.sv
// Output stage of the fp8 add/sub datapath: round-to-nearest-even, exception
// classification, result packing, 2-entry output FIFO and exception counters.
module fp8_round_pack #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  fp8_round_pack_if.slave  bus,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic [CNT_W-1:0] unf_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t state;
  occ_t state_next;

  logic              [3:0] frac;
  logic                    guard;
  logic                    rnd;
  logic                    sticky;
  logic                    round_up;
  logic              [4:0] frac_sum;
  logic signed       [4:0] exp_pre;
  logic signed       [4:0] exp_fin;
  logic                    is_zero;
  logic                    is_unf;
  logic                    is_ovf;
  logic              [7:0] res_data;
  logic              [2:0] res_flags;

  logic       ready_int;
  logic       valid_int;
  logic       push;
  logic       pop;
  logic       load_head_in;
  logic       load_head_tail;
  logic       load_tail;
  logic [7:0] head_data;
  logic [2:0] head_flags;
  logic [7:0] tail_data;
  logic [2:0] tail_flags;

  // Underflow is judged on the pre-rounding exponent; overflow on the exponent
  // after a possible rounding carry out of the fraction.
  always_comb begin
    frac   = bus.in_mant[6:3];
    guard  = bus.in_mant[2];
    rnd    = bus.in_mant[1];
    sticky = bus.in_mant[0];

    if (bus.in_shift == 3'd7) begin
      exp_pre = $signed({2'b00, bus.in_big_exp}) + 5'sd1;
    end else begin
      exp_pre = $signed({2'b00, bus.in_big_exp}) - $signed({2'b00, bus.in_shift});
    end

    round_up = guard & (rnd | sticky | frac[0]);
    frac_sum = {1'b0, frac} + {4'd0, round_up};
    exp_fin  = exp_pre + $signed({4'd0, frac_sum[4]});

    is_zero = (bus.in_mant == 8'h00);
    is_unf  = !is_zero && (exp_pre < 5'sd0);
    is_ovf  = !is_zero && !is_unf && (exp_fin > 5'sd7);

    res_data  = {bus.in_sign, exp_fin[2:0], frac_sum[3:0]};
    res_flags = 3'b000;
    if (is_zero) begin
      res_data  = 8'h00;
      res_flags = 3'b001;
    end else if (is_unf) begin
      res_data  = {bus.in_sign, 7'b000_0000};
      res_flags = 3'b010;
    end else if (is_ovf) begin
      res_data  = {bus.in_sign, 7'b111_1111};
      res_flags = 3'b100;
    end
  end

  assign ready_int = (int'(state) != FIFO_DEPTH);
  assign valid_int = (state != EMPTY);
  assign push      = bus.in_valid & ready_int;
  assign pop       = valid_int & bus.out_ready;

  assign bus.in_ready  = ready_int;
  assign bus.out_valid = valid_int;
  assign bus.out_data  = head_data;
  assign bus.out_flags = head_flags;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // The head register is the visible output, so it is only reloaded when a new
  // entry becomes the head; draining to empty leaves the last result showing.
  always_comb begin
    state_next     = state;
    load_head_in   = 1'b0;
    load_head_tail = 1'b0;
    load_tail      = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          load_head_in = 1'b1;
          state_next   = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          load_head_in = 1'b1;
        end else if (push) begin
          load_tail  = 1'b1;
          state_next = FULL;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          load_head_tail = 1'b1;
          state_next     = ONE;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_data  <= 8'h00;
      head_flags <= 3'b000;
      tail_data  <= 8'h00;
      tail_flags <= 3'b000;
    end else begin
      if (load_head_in) begin
        head_data  <= res_data;
        head_flags <= res_flags;
      end else if (load_head_tail) begin
        head_data  <= tail_data;
        head_flags <= tail_flags;
      end
      if (load_tail) begin
        tail_data  <= res_data;
        tail_flags <= res_flags;
      end
    end
  end

  // Clear wins over a same-cycle increment; counts stick at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
      unf_cnt <= '0;
    end else if (clr_stats) begin
      ovf_cnt <= '0;
      unf_cnt <= '0;
    end else begin
      if (push && res_flags[2] && (ovf_cnt != '1)) begin
        ovf_cnt <= ovf_cnt + 1'b1;
      end
      if (push && res_flags[1] && (unf_cnt != '1)) begin
        unf_cnt <= unf_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fp8_round_pack.sv
// Table-driven, scoreboard-checked bench for fp8_round_pack: rounding and
// classification vectors plus backpressure, clear, saturation and reset cases.
module tb_fp8_round_pack;

  typedef struct {
    logic       sign;
    logic [2:0] big_exp;
    logic [2:0] shift;
    logic [7:0] mant;
    logic [7:0] data;
    logic [2:0] flags;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       clr_stats;
  logic [7:0] ovf_cnt;
  logic [7:0] unf_cnt;

  fp8_round_pack_if bus();

  fp8_round_pack #(
    .FIFO_DEPTH (2),
    .CNT_W      (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .clr_stats (clr_stats),
    .ovf_cnt   (ovf_cnt),
    .unf_cnt   (unf_cnt)
  );

  vec_t        vecs [20];
  logic [10:0] sb [$];
  int          n_applied;
  int          n_miss;
  int          exp_ovf;
  int          exp_unf;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_applied++;
    if (act !== expv) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic applyStimulus(input vec_t v);
    bit got_ready;
    got_ready      = 1'b0;
    bus.in_valid   = 1'b1;
    bus.in_sign    = v.sign;
    bus.in_big_exp = v.big_exp;
    bus.in_shift   = v.shift;
    bus.in_mant    = v.mant;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got_ready = 1'b1;
        break;
      end
    end
    if (!got_ready) begin
      checkOutput("in_ready_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
    end else begin
      sb.push_back({v.data, v.flags});
      if (clr_stats) begin
        exp_ovf = 0;
        exp_unf = 0;
      end else begin
        if (v.flags[2] && exp_ovf < 255) exp_ovf++;
        if (v.flags[1] && exp_unf < 255) exp_unf++;
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    checkOutput("drain_empty", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
      end else begin
        logic [10:0] e;
        e = sb.pop_front();
        checkOutput("out_data", 32'(bus.out_data), 32'(e[10:3]));
        checkOutput("out_flags", 32'(bus.out_flags), 32'(e[2:0]));
      end
    end
  end

  initial begin
    vec_t ovf_v;
    n_applied = 0;
    n_miss    = 0;
    exp_ovf   = 0;
    exp_unf   = 0;

    vecs[0]  = '{1'b0, 3'd3, 3'd0, 8'hB4, 8'h36, 3'b000};
    vecs[1]  = '{1'b0, 3'd3, 3'd1, 8'hBE, 8'h28, 3'b000};
    vecs[2]  = '{1'b0, 3'd5, 3'd0, 8'hFC, 8'h60, 3'b000};
    vecs[3]  = '{1'b1, 3'd7, 3'd7, 8'h80, 8'hFF, 3'b100};
    vecs[4]  = '{1'b1, 3'd7, 3'd0, 8'hFC, 8'hFF, 3'b100};
    vecs[5]  = '{1'b1, 3'd1, 3'd3, 8'h90, 8'h80, 3'b010};
    vecs[6]  = '{1'b1, 3'd0, 3'd0, 8'h00, 8'h00, 3'b001};
    vecs[7]  = '{1'b0, 3'd0, 3'd0, 8'h80, 8'h00, 3'b000};
    vecs[8]  = '{1'b0, 3'd7, 3'd0, 8'hF8, 8'h7F, 3'b000};
    vecs[9]  = '{1'b0, 3'd2, 3'd2, 8'h84, 8'h00, 3'b000};
    vecs[10] = '{1'b0, 3'd0, 3'd1, 8'h80, 8'h00, 3'b010};
    vecs[11] = '{1'b0, 3'd6, 3'd7, 8'h8C, 8'h72, 3'b000};
    vecs[12] = '{1'b0, 3'd4, 3'd2, 8'hA5, 8'h25, 3'b000};
    vecs[13] = '{1'b1, 3'd7, 3'd7, 8'h00, 8'h00, 3'b001};
    vecs[14] = '{1'b0, 3'd0, 3'd1, 8'hFC, 8'h00, 3'b010};
    vecs[15] = '{1'b1, 3'd6, 3'd7, 8'hF8, 8'hFF, 3'b000};
    vecs[16] = '{1'b1, 3'd2, 3'd0, 8'hC0, 8'hA8, 3'b000};
    vecs[17] = '{1'b0, 3'd4, 3'd1, 8'h8F, 8'h32, 3'b000};
    vecs[18] = '{1'b0, 3'd3, 3'd7, 8'hFE, 8'h50, 3'b000};
    vecs[19] = '{1'b0, 3'd7, 3'd7, 8'h90, 8'h7F, 3'b100};
    ovf_v    = vecs[3];

    rst_n          = 1'b0;
    clr_stats      = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_sign    = 1'b0;
    bus.in_big_exp = 3'd0;
    bus.in_shift   = 3'd0;
    bus.in_mant    = 8'h00;
    bus.out_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    @(negedge clk);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(bus.out_data), 32'h00);
    checkOutput("rst_out_flags", 32'(bus.out_flags), 32'd0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
    checkOutput("rst_unf_cnt", 32'(unf_cnt), 32'd0);
    @(posedge clk);
    #1;

    applyStimulus(vecs[0]);
    @(negedge clk);
    checkOutput("latency_out_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("latency_out_data", 32'(bus.out_data), 32'h36);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i]);
      checkOutput("ovf_cnt", 32'(ovf_cnt), 32'(exp_ovf));
      checkOutput("unf_cnt", 32'(unf_cnt), 32'(exp_unf));
    end
    drain();

    bus.out_ready = 1'b0;
    applyStimulus(vecs[1]);
    applyStimulus(vecs[2]);
    bus.in_valid   = 1'b1;
    bus.in_sign    = vecs[17].sign;
    bus.in_big_exp = vecs[17].big_exp;
    bus.in_shift   = vecs[17].shift;
    bus.in_mant    = vecs[17].mant;
    bus.out_ready  = 1'b1;
    @(negedge clk);
    checkOutput("full_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("full_head_data", 32'(bus.out_data), 32'h28);
    @(negedge clk);
    checkOutput("after_pop_in_ready", 32'(bus.in_ready), 32'd1);
    sb.push_back({vecs[17].data, vecs[17].flags});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("third_out_valid", 32'(bus.out_valid), 32'd1);
    @(negedge clk);
    checkOutput("drained_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("hold_last_data", 32'(bus.out_data), 32'h32);
    checkOutput("bp_queue_empty", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;

    checkOutput("pre_clr_ovf_cnt", 32'(ovf_cnt), 32'd3);
    clr_stats = 1'b1;
    applyStimulus(ovf_v);
    clr_stats = 1'b0;
    checkOutput("clr_ovf_cnt", 32'(ovf_cnt), 32'd0);
    checkOutput("clr_unf_cnt", 32'(unf_cnt), 32'd0);

    for (int i = 0; i < 300; i++) applyStimulus(ovf_v);
    checkOutput("sat_ovf_cnt", 32'(ovf_cnt), 32'(exp_ovf));
    checkOutput("sat_ovf_255", 32'(ovf_cnt), 32'd255);
    checkOutput("sat_unf_cnt", 32'(unf_cnt), 32'd0);
    drain();

    bus.out_ready = 1'b0;
    applyStimulus(vecs[1]);
    applyStimulus(vecs[2]);
    @(negedge clk);
    checkOutput("queued_out_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    exp_ovf = 0;
    exp_unf = 0;
    @(negedge clk);
    checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midrst_out_data", 32'(bus.out_data), 32'h00);
    checkOutput("midrst_out_flags", 32'(bus.out_flags), 32'd0);
    checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("midrst_ovf_cnt", 32'(ovf_cnt), 32'd0);
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

endmodule
